// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: load-op encoding, exception codes
// carried in the side payload, and the discard-counter width.
package mem_stage_pkg;

  // Bit positions inside the one-hot load_op vector.
  localparam int LD_B  = 0;
  localparam int LD_H  = 1;
  localparam int LD_W  = 2;
  localparam int LD_BU = 3;
  localparam int LD_HU = 4;
  localparam int LOAD_OP_W = 5;

  // Exception codes and subcodes that travel opaquely in the side payload.
  localparam logic [5:0] ECODE_INT = 6'h00;
  localparam logic [5:0] ECODE_ADE = 6'h08;
  localparam logic [5:0] ECODE_ALE = 6'h09;
  localparam logic [5:0] ECODE_SYS = 6'h0b;
  localparam logic [5:0] ECODE_BRK = 6'h0c;
  localparam logic [5:0] ECODE_INE = 6'h0d;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

  // Up to 2^DISCARD_CNT_W-1 flushed requests may still be in flight.
  localparam int DISCARD_CNT_W = 2;

endpackage

// File: rtl/mem_load_align.sv
// Byte-lane selection and sign/zero extension of load response data.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0]          rdata,
  input  logic [1:0]           addr_low2,
  input  logic [LOAD_OP_W-1:0] load_op,
  output logic [31:0]          value
);

  logic [31:0] shifted;

  // Bring the addressed byte/halfword down to bit 0.
  assign shifted = rdata >> {addr_low2, 3'b000};

  // Extend according to load type; ld_w takes the full (unshifted, aligned) word.
  always_comb begin
    value = shifted;
    if (load_op[LD_B])
      value = {{24{shifted[7]}}, shifted[7:0]};
    else if (load_op[LD_BU])
      value = {24'b0, shifted[7:0]};
    else if (load_op[LD_H])
      value = {{16{shifted[15]}}, shifted[15:0]};
    else if (load_op[LD_HU])
      value = {16'b0, shifted[15:0]};
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: completes data-SRAM loads/stores, holds a response while WB
// stalls, discards responses of flushed instructions, and feeds ID forwarding.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int SIDE_W = 128,
  parameter int CNT_W  = DISCARD_CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_mem_valid,
  output logic              mem_allowin,
  input  logic              ex_gr_we,
  input  logic              ex_res_from_mem,
  input  logic [4:0]        ex_load_op,
  input  logic [1:0]        ex_addr_low2,
  input  logic              ex_req_sent,
  input  logic [4:0]        ex_dest,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_result,
  input  logic              ex_ex,
  input  logic              ex_ertn,
  input  logic [SIDE_W-1:0] ex_side,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allowin,
  input  logic              wb_ex,
  input  logic              ertn_flush,
  output logic              mem_wb_valid,
  output logic              mem_wb_gr_we,
  output logic [4:0]        mem_wb_dest,
  output logic [31:0]       mem_wb_pc,
  output logic [31:0]       mem_wb_result,
  output logic              mem_wb_ex,
  output logic              mem_wb_ertn,
  output logic [SIDE_W-1:0] mem_wb_side,
  output logic              mem_ex,
  output logic              mem_ertn,
  output logic              fwd_valid,
  output logic              fwd_block,
  output logic [4:0]        fwd_dest,
  output logic [31:0]       fwd_data
);

  // Control state
  logic             mem_valid;
  logic             need_data;
  logic             data_held;
  logic [CNT_W-1:0] discard_cnt;
  logic [31:0]      held_rdata;

  // Latched EX payload
  logic              gr_we;
  logic              res_from_mem;
  logic [4:0]        load_op;
  logic [1:0]        addr_low2;
  logic [4:0]        dest;
  logic [31:0]       pc;
  logic [31:0]       result;
  logic              exc;
  logic              ertn;
  logic [SIDE_W-1:0] side;

  logic        flush;
  logic        own_ok;
  logic        mem_ready_go;
  logic        accept;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:0] rdata_sel;
  logic [31:0] load_value;

  assign flush        = wb_ex | ertn_flush;
  // A response is ours only when no flushed request is still ahead of it.
  assign own_ok       = data_sram_data_ok & (discard_cnt == '0) & mem_valid
                      & need_data & ~data_held;
  // Excepting instructions never issued a request, so they never wait.
  assign mem_ready_go = ~need_data | data_held | own_ok | exc;
  assign mem_allowin  = ~mem_valid | (mem_ready_go & wb_allowin);
  assign mem_wb_valid = mem_valid & mem_ready_go;
  assign accept       = ex_mem_valid & mem_allowin & ~flush;
  // A flushed instruction still waiting leaves one stray response behind.
  assign cnt_inc      = flush & mem_valid & need_data & ~data_held & ~own_ok;
  assign cnt_dec      = data_sram_data_ok & (discard_cnt != '0);

  assign rdata_sel = own_ok ? data_sram_rdata : held_rdata;

  mem_load_align u_align (
    .rdata     (rdata_sel),
    .addr_low2 (addr_low2),
    .load_op   (load_op),
    .value     (load_value)
  );

  assign mem_wb_result = res_from_mem ? load_value : result;
  assign mem_wb_gr_we  = gr_we;
  assign mem_wb_dest   = dest;
  assign mem_wb_pc     = pc;
  assign mem_wb_ex     = exc;
  assign mem_wb_ertn   = ertn;
  assign mem_wb_side   = side;
  assign mem_ex        = mem_valid & exc;
  assign mem_ertn      = mem_valid & ertn;
  assign fwd_valid     = mem_valid & gr_we & ~exc;
  assign fwd_block     = fwd_valid & res_from_mem & ~mem_ready_go;
  assign fwd_dest      = dest;
  assign fwd_data      = mem_wb_result;

  // Instruction occupancy, outstanding-request tracking and response buffering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid   <= 1'b0;
      need_data   <= 1'b0;
      data_held   <= 1'b0;
      discard_cnt <= '0;
      held_rdata  <= '0;
    end else begin
      if (flush)
        mem_valid <= 1'b0;
      else if (mem_allowin)
        mem_valid <= ex_mem_valid;

      if (accept)
        need_data <= ex_req_sent;
      else if (flush || mem_allowin)
        need_data <= 1'b0;

      if (flush || mem_allowin)
        data_held <= 1'b0;
      else if (own_ok)
        data_held <= 1'b1;

      if (own_ok)
        held_rdata <= data_sram_rdata;

      if (cnt_inc && !cnt_dec)
        discard_cnt <= discard_cnt + CNT_W'(1);
      else if (cnt_dec && !cnt_inc)
        discard_cnt <= discard_cnt - CNT_W'(1);
    end
  end

  // Capture the EX payload when an instruction is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gr_we        <= 1'b0;
      res_from_mem <= 1'b0;
      load_op      <= '0;
      addr_low2    <= '0;
      dest         <= '0;
      pc           <= '0;
      result       <= '0;
      exc          <= 1'b0;
      ertn         <= 1'b0;
      side         <= '0;
    end else if (accept) begin
      gr_we        <= ex_gr_we;
      res_from_mem <= ex_res_from_mem;
      load_op      <= ex_load_op;
      addr_low2    <= ex_addr_low2;
      dest         <= ex_dest;
      pc           <= ex_pc;
      result       <= ex_result;
      exc          <= ex_ex;
      ertn         <= ex_ertn;
      side         <= ex_side;
    end
  end

  // A response with nothing waiting for it and nothing to discard is a protocol error.
  a_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(data_sram_data_ok && discard_cnt == '0 && !(mem_valid && need_data)));

  // More flushed requests than the counter can track.
  a_discard_sat: assert property (@(posedge clk) disable iff (!resetn)
    !(cnt_inc && !cnt_dec && discard_cnt == '1));

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads
// compared against a byte-arithmetic reference of the load extension rules.
module tb_mem_stage;

  localparam int SIDE_W = 128;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              resetn;
  logic              ex_mem_valid;
  logic              mem_allowin;
  logic              ex_gr_we;
  logic              ex_res_from_mem;
  logic [4:0]        ex_load_op;
  logic [1:0]        ex_addr_low2;
  logic              ex_req_sent;
  logic [4:0]        ex_dest;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_result;
  logic              ex_ex;
  logic              ex_ertn;
  logic [SIDE_W-1:0] ex_side;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              wb_allowin;
  logic              wb_ex;
  logic              ertn_flush;
  logic              mem_wb_valid;
  logic              mem_wb_gr_we;
  logic [4:0]        mem_wb_dest;
  logic [31:0]       mem_wb_pc;
  logic [31:0]       mem_wb_result;
  logic              mem_wb_ex;
  logic              mem_wb_ertn;
  logic [SIDE_W-1:0] mem_wb_side;
  logic              mem_ex;
  logic              mem_ertn;
  logic              fwd_valid;
  logic              fwd_block;
  logic [4:0]        fwd_dest;
  logic [31:0]       fwd_data;

  int errors = 0;
  int checks = 0;

  mem_stage #(.SIDE_W(SIDE_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
    .ex_gr_we(ex_gr_we), .ex_res_from_mem(ex_res_from_mem),
    .ex_load_op(ex_load_op), .ex_addr_low2(ex_addr_low2),
    .ex_req_sent(ex_req_sent), .ex_dest(ex_dest), .ex_pc(ex_pc),
    .ex_result(ex_result), .ex_ex(ex_ex), .ex_ertn(ex_ertn), .ex_side(ex_side),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .wb_allowin(wb_allowin), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .mem_wb_valid(mem_wb_valid), .mem_wb_gr_we(mem_wb_gr_we),
    .mem_wb_dest(mem_wb_dest), .mem_wb_pc(mem_wb_pc),
    .mem_wb_result(mem_wb_result), .mem_wb_ex(mem_wb_ex),
    .mem_wb_ertn(mem_wb_ertn), .mem_wb_side(mem_wb_side),
    .mem_ex(mem_ex), .mem_ertn(mem_ertn),
    .fwd_valid(fwd_valid), .fwd_block(fwd_block),
    .fwd_dest(fwd_dest), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: load type index 0 ld_b, 1 ld_h, 2 ld_w, 3 ld_bu, 4 ld_hu.
  function automatic logic [31:0] exp_load(int op, int off, logic [31:0] rd);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      0: return (b >= 32'd128)   ? b - 32'd256   : b;
      1: return (h >= 32'd32768) ? h - 32'd65536 : h;
      2: return rd;
      3: return b;
      default: return h;
    endcase
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    ex_mem_valid = 1'b0; ex_gr_we = 1'b0; ex_res_from_mem = 1'b0;
    ex_load_op = '0; ex_addr_low2 = '0; ex_req_sent = 1'b0; ex_dest = '0;
    ex_pc = '0; ex_result = '0; ex_ex = 1'b0; ex_ertn = 1'b0; ex_side = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    wb_allowin = 1'b1; wb_ex = 1'b0; ertn_flush = 1'b0;
  endtask

  task automatic drive_ex(input logic [4:0] op, input logic [1:0] off,
                          input logic req, input logic rfm,
                          input logic [31:0] res, input logic [4:0] dst,
                          input logic exc, input logic ert,
                          input logic [31:0] pc, input logic [SIDE_W-1:0] sd);
    ex_mem_valid = 1'b1; ex_gr_we = 1'b1; ex_res_from_mem = rfm;
    ex_load_op = op; ex_addr_low2 = off; ex_req_sent = req; ex_dest = dst;
    ex_result = res; ex_ex = exc; ex_ertn = ert; ex_pc = pc; ex_side = sd;
  endtask

  task automatic test_reset;
    logic [300:0] outs;
    resetn = 1'b0;
    drive_idle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    outs = {mem_wb_valid, mem_wb_gr_we, mem_wb_dest, mem_wb_pc, mem_wb_result,
            mem_wb_ex, mem_wb_ertn, mem_ex, mem_ertn, fwd_valid, fwd_block,
            fwd_dest, fwd_data, mem_wb_side};
    checks++;
    if (outs !== '0) begin
      errors++; $display("FAIL reset_outs got=%h exp=0", outs);
    end
    checks++;
    if (mem_allowin !== 1'b1) begin
      errors++; $display("FAIL reset_allowin got=%b exp=1", mem_allowin);
    end
    resetn = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({mem_allowin, mem_wb_valid, fwd_valid} !== 3'b100) begin
      errors++; $display("FAIL post_reset_idle got=%b exp=100", {mem_allowin, mem_wb_valid, fwd_valid});
    end
    next_cycle();
  endtask

  task automatic test_ld_b;
    drive_ex(5'b00001, 2'd3, 1'b1, 1'b1, 32'h0, 5'd5, 1'b0, 1'b0, 32'h1c00_0010, '0);
    next_cycle();
    drive_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({fwd_block, mem_wb_valid, mem_allowin} !== 3'b100) begin
        errors++; $display("FAIL ldb_wait%0d block/wbv/allowin got=%b exp=100", c, {fwd_block, mem_wb_valid, mem_allowin});
      end
      next_cycle();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_0000;
    @(negedge clk);
    checks++;
    if ({fwd_block, mem_wb_valid} !== 2'b01) begin
      errors++; $display("FAIL ldb_done block/wbv got=%b exp=01", {fwd_block, mem_wb_valid});
    end
    checks++;
    if (mem_wb_result !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL ldb_result got=%h exp=ffffff80", mem_wb_result);
    end
    checks++;
    if (fwd_data !== 32'hFFFF_FF80 || fwd_dest !== 5'd5) begin
      errors++; $display("FAIL ldb_fwd got=%h/%0d exp=ffffff80/5", fwd_data, fwd_dest);
    end
    next_cycle();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_wb_valid, mem_allowin} !== 2'b01) begin
      errors++; $display("FAIL ldb_pulse wbv/allowin got=%b exp=01", {mem_wb_valid, mem_allowin});
    end
    next_cycle();
  endtask

  task automatic test_ld_hu_stall;
    drive_ex(5'b10000, 2'd2, 1'b1, 1'b1, 32'h0, 5'd6, 1'b0, 1'b0, 32'h1c00_0020, '0);
    next_cycle();
    drive_idle();
    wb_allowin = 1'b0;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_wb_valid, mem_allowin} !== 2'b10 || mem_wb_result !== 32'h0000_BEEF) begin
        errors++; $display("FAIL ldhu_stall%0d wbv/allowin=%b res=%h exp=10/0000beef", c, {mem_wb_valid, mem_allowin}, mem_wb_result);
      end
      next_cycle();
      data_sram_data_ok = 1'b0; data_sram_rdata = 32'h5555_AAAA;
    end
    wb_allowin = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_wb_valid, mem_allowin} !== 2'b11 || mem_wb_result !== 32'h0000_BEEF) begin
      errors++; $display("FAIL ldhu_release wbv/allowin=%b res=%h exp=11/0000beef", {mem_wb_valid, mem_allowin}, mem_wb_result);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (mem_wb_valid !== 1'b0) begin
      errors++; $display("FAIL ldhu_retired got=%b exp=0", mem_wb_valid);
    end
    next_cycle();
  endtask

  task automatic test_flush_discard;
    drive_ex(5'b00100, 2'd0, 1'b1, 1'b1, 32'h0, 5'd8, 1'b0, 1'b0, 32'h1c00_0030, '0);
    next_cycle();
    drive_idle();
    wb_ex = 1'b1;
    next_cycle();
    wb_ex = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_wb_valid, fwd_valid, mem_allowin} !== 3'b001) begin
      errors++; $display("FAIL flush_kill wbv/fwdv/allowin got=%b exp=001", {mem_wb_valid, fwd_valid, mem_allowin});
    end
    drive_ex(5'b00100, 2'd0, 1'b1, 1'b1, 32'h0, 5'd9, 1'b0, 1'b0, 32'h1c00_0034, '0);
    next_cycle();
    drive_idle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({mem_wb_valid, fwd_block} !== 2'b01) begin
      errors++; $display("FAIL discard_first wbv/block got=%b exp=01", {mem_wb_valid, fwd_block});
    end
    next_cycle();
    data_sram_rdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (mem_wb_valid !== 1'b1 || mem_wb_result !== 32'h1234_5678) begin
      errors++; $display("FAIL discard_second wbv=%b res=%h exp=1/12345678", mem_wb_valid, mem_wb_result);
    end
    next_cycle();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_alu;
    drive_ex(5'b00000, 2'd0, 1'b0, 1'b0, 32'h0000_0042, 5'd7, 1'b0, 1'b0, 32'h1c00_0040, '0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if ({mem_wb_valid, fwd_valid, fwd_block} !== 3'b110) begin
      errors++; $display("FAIL alu_flags wbv/fwdv/block got=%b exp=110", {mem_wb_valid, fwd_valid, fwd_block});
    end
    checks++;
    if (fwd_data !== 32'h42 || fwd_dest !== 5'd7 || mem_wb_gr_we !== 1'b1) begin
      errors++; $display("FAIL alu_fwd data=%h dest=%0d we=%b exp=42/7/1", fwd_data, fwd_dest, mem_wb_gr_we);
    end
    next_cycle();
  endtask

  task automatic test_exception;
    logic [SIDE_W-1:0] sd;
    sd = {$urandom(), $urandom(), $urandom(), $urandom()};
    drive_ex(5'b00100, 2'd0, 1'b1, 1'b1, 32'h0, 5'd9, 1'b1, 1'b1, 32'h1c00_0050, sd);
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if ({mem_ex, mem_ertn, fwd_valid, mem_wb_valid, mem_wb_ex, mem_wb_ertn} !== 6'b110111) begin
      errors++; $display("FAIL exc_flags got=%b exp=110111", {mem_ex, mem_ertn, fwd_valid, mem_wb_valid, mem_wb_ex, mem_wb_ertn});
    end
    checks++;
    if (mem_wb_side !== sd || mem_wb_pc !== 32'h1c00_0050) begin
      errors++; $display("FAIL exc_payload side=%h pc=%h exp=%h/1c000050", mem_wb_side, mem_wb_pc, sd);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({mem_wb_valid, mem_ex} !== 2'b00) begin
      errors++; $display("FAIL exc_retired got=%b exp=00", {mem_wb_valid, mem_ex});
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait;
    drive_ex(5'b00100, 2'd0, 1'b1, 1'b1, 32'h0, 5'd10, 1'b0, 1'b0, 32'h1c00_0060, '0);
    next_cycle();
    drive_idle();
    ertn_flush = 1'b1;
    next_cycle();
    ertn_flush = 1'b0;
    drive_ex(5'b00100, 2'd0, 1'b1, 1'b1, 32'h0, 5'd11, 1'b0, 1'b0, 32'h1c00_0064, '0);
    next_cycle();
    drive_idle();
    @(negedge clk);
    checks++;
    if (fwd_block !== 1'b1) begin
      errors++; $display("FAIL rst_pre_wait got=%b exp=1", fwd_block);
    end
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_allowin, mem_wb_valid, fwd_valid, fwd_block} !== 4'b1000 || mem_wb_pc !== 32'h0) begin
      errors++; $display("FAIL rst_cleared flags=%b pc=%h exp=1000/0", {mem_allowin, mem_wb_valid, fwd_valid, fwd_block}, mem_wb_pc);
    end
    // With the discard count cleared, the very next response must be owned.
    drive_ex(5'b00100, 2'd0, 1'b1, 1'b1, 32'h0, 5'd12, 1'b0, 1'b0, 32'h1c00_0068, '0);
    next_cycle();
    drive_idle();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    checks++;
    if (mem_wb_valid !== 1'b1 || mem_wb_result !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL rst_cnt_clear wbv=%b res=%h exp=1/cafef00d", mem_wb_valid, mem_wb_result);
    end
    next_cycle();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_random_loads;
    for (int it = 0; it < 40; it++) begin
      int op, off, dly, stall;
      logic [31:0] rd, pc, exp;
      op = $urandom_range(0, 4);
      if (op == 2) off = 0;
      else if (op == 1 || op == 4) off = 2 * $urandom_range(0, 1);
      else off = $urandom_range(0, 3);
      rd = $urandom(); pc = $urandom();
      dly = $urandom_range(0, 3); stall = $urandom_range(0, 2);
      exp = exp_load(op, off, rd);
      drive_ex(5'(1 << op), 2'(off), 1'b1, 1'b1, $urandom(), 5'(it), 1'b0, 1'b0, pc, '0);
      next_cycle();
      drive_idle();
      for (int c = 0; c < dly; c++) begin
        @(negedge clk);
        checks++;
        if ({mem_wb_valid, fwd_block} !== 2'b01) begin
          errors++; $display("FAIL rnd%0d_wait wbv/block got=%b exp=01", it, {mem_wb_valid, fwd_block});
        end
        next_cycle();
      end
      data_sram_data_ok = 1'b1; data_sram_rdata = rd;
      wb_allowin = (stall == 0);
      @(negedge clk);
      checks++;
      if (mem_wb_valid !== 1'b1 || mem_wb_result !== exp || mem_wb_pc !== pc) begin
        errors++; $display("FAIL rnd%0d_op%0d_off%0d wbv=%b res=%h pc=%h exp=1/%h/%h", it, op, off, mem_wb_valid, mem_wb_result, mem_wb_pc, exp, pc);
      end
      next_cycle();
      data_sram_data_ok = 1'b0; data_sram_rdata = $urandom();
      for (int s = 1; s <= stall; s++) begin
        wb_allowin = (s == stall);
        @(negedge clk);
        checks++;
        if (mem_wb_result !== exp || mem_allowin !== (s == stall)) begin
          errors++; $display("FAIL rnd%0d_held res=%h allowin=%b exp=%h/%b", it, mem_wb_result, mem_allowin, exp, (s == stall));
        end
        next_cycle();
      end
      wb_allowin = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_wb_valid !== 1'b0) begin
        errors++; $display("FAIL rnd%0d_retired got=%b exp=0", it, mem_wb_valid);
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_ld_b();
    test_ld_hu_stall();
    test_flush_discard();
    test_alu();
    test_exception();
    test_reset_mid_wait();
    test_random_loads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage LoongArch pipeline. It sits between EX and WB.
- It receives the EX payload and completes outstanding data-SRAM loads and stores over the data_ok/rdata response channel, and sign- or zero-extends the load data.
- It buffers a response that arrives while WB stalls, and drops responses that belong to flushed instructions.
- It drives the ID forwarding/interlock bus and the mem_ex/mem_ertn signals that EX uses to suppress stores.

Parameters:
SIDE_W, 128, width of the opaque side payload (CSR fields, ertn/syscall flags, ecode/esubcode, bad address), passed EX to WB unchanged
CNT_W, 2, width of the discard counter; supports up to 2^CNT_W-1 flushed in-flight requests

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
ex_mem_valid  in  1  EX holds a valid instruction ready to pass
mem_allowin  out  1  MEM can accept this cycle
ex_gr_we  in  1  instruction writes a GPR
ex_res_from_mem  in  1  result comes from load data
ex_load_op  in  5  one-hot load type: [0]ld_b [1]ld_h [2]ld_w [3]ld_bu [4]ld_hu
ex_addr_low2  in  2  byte offset of the access
ex_req_sent  in  1  EX issued a data request that received addr_ok
ex_dest  in  5  destination GPR
ex_pc  in  32  instruction PC
ex_result  in  32  ALU/div/counter result
ex_ex  in  1  instruction carries an exception
ex_ertn  in  1  instruction is ertn
ex_side  in  SIDE_W  opaque pass-through
data_sram_data_ok  in  1  data response valid
data_sram_rdata  in  32  response read data
wb_allowin  in  1  WB can accept
wb_ex  in  1  exception flush from WB
ertn_flush  in  1  ertn flush from WB
mem_wb_valid  out  1  valid instruction passed to WB
mem_wb_gr_we, mem_wb_dest, mem_wb_pc, mem_wb_result, mem_wb_ex, mem_wb_ertn, mem_wb_side  out  1/5/32/32/1/1/SIDE_W  WB payload
mem_ex  out  1  mem_valid & ex_ex
mem_ertn  out  1  mem_valid & ex_ertn
fwd_valid  out  1  forwarding candidate: mem_valid & gr_we & ~ex_ex
fwd_block  out  1  load result not yet available; ID must stall
fwd_dest  out  5  forwarding destination
fwd_data  out  32  forwarding value (final result)

Behaviour:
- Reset: mem_valid, need_data, data_held, discard_cnt, held_rdata and all payload registers clear to 0. As a result every output is 0 except mem_allowin, which is 1.
- mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin). mem_wb_valid = mem_valid & mem_ready_go.
- Accept happens when ex_mem_valid & mem_allowin & ~(wb_ex|ertn_flush). On accept, latch the payload and set need_data = ex_req_sent. Otherwise mem_valid <= 0 when mem_allowin is high.
- Per-instruction FSM:
  - IDLE (no instruction).
  - WAIT (need_data & ~data_held): on an owned data_ok, go to DONE if wb_allowin is 0, else retire.
  - DONE (data_held=1, held_rdata latched).
  - READY (no request).
  - Retire occurs when mem_wb_valid & wb_allowin.
- mem_ready_go = ~need_data | data_held | own_ok.
  - own_ok = data_sram_data_ok & (discard_cnt==0) & mem_valid & need_data & ~data_held.
  - mem_ready_go is also 1 when ex_ex=1, because EX never issues a request for an excepting instruction.
- rdata selection: own_ok ? data_sram_rdata : held_rdata, shifted right by 8*addr_low2.
  - ld_b: sign-extend byte. ld_bu: zero-extend byte.
  - ld_h: sign-extend halfword at offset[1]. ld_hu: zero-extend halfword at offset[1].
  - ld_w: full word.
  - mem_wb_result = res_from_mem ? extended : ex_result.
- Discard:
  - If wb_ex or ertn_flush is asserted while mem_valid & need_data & ~data_held & ~own_ok, then discard_cnt++ and mem_valid <= 0.
  - While discard_cnt > 0, each data_ok decrements the counter and is ignored.
  - A flush that coincides with own_ok does not increment the counter.
- Flush in any state kills mem_valid the next cycle and clears data_held.
- A data_ok with mem_valid=0 or need_data=0 and discard_cnt==0 is a protocol error. It is ignored, and an assertion is raised in simulation.
- discard_cnt saturation is an assertion error.
- fwd_block = fwd_valid & res_from_mem & ~mem_ready_go. fwd_data = mem_wb_result.
- Stores: need_data=1 and data_ok completes the instruction; the data value is unused.

Decomposition:
- Shared package holds:
  - LOAD_OP bit indices.
  - ECODE/ESUBCODE constants.
  - Discard-counter width.
- One combinational sub-module, mem_load_align, takes rdata, addr_low2 and load_op and produces the 32-bit extended value.
- The FSM and counters stay in mem_stage.

Test Plan:
- ld_b at addr_low2=3, rdata=0x80FF_0000, data_ok 2 cycles after accept, wb_allowin=1 -> result 0xFFFF_FF80; fwd_block=1 for 2 cycles and then 0; mem_wb_valid pulses for 1 cycle.
- ld_hu at offset 2, rdata=0xBEEF_1234, data_ok while wb_allowin=0 for 3 cycles -> held_rdata kept; mem_wb_result=0x0000_BEEF; retire when wb_allowin rises; mem_allowin=0 until then.
- ld_w waiting, wb_ex pulse before data_ok -> mem_valid=0 next cycle. A new ld_w is accepted. The first data_ok (0xDEAD_BEEF) is discarded; the second (0x1234_5678) is written back.
- Non-memory add, ex_result=0x42, ex_req_sent=0 -> mem_wb_valid in the same cycle as valid; fwd_valid=1, fwd_block=0, fwd_data=0x42.
- Instruction with ex_ex=1 and ex_ertn=1 -> mem_ex=1 and mem_ertn=1; fwd_valid=0; passes to WB without waiting for data_ok.
- Reset asserted mid-WAIT with discard_cnt=1 -> all state cleared; mem_allowin=1 after reset.
